apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_arb_master_if.sv | 27 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/apb_arb_master.sv | 129 ++++++++++++
 tb/tb_apb_arb_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the two-requester APB master.
package apb_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// APB bus between the arbitrating master and a single completer.
interface apb_arb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer advances only when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // last = 1 means requester 1 won most recently; reset favours requester 0.
    logic last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master serving two requesters, one transfer at a time, with a wait timeout.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ack,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output apb_state_e              dbg_state,
    apb_arb_master_if.master        apb
);

    // Handshake: req_valid is sampled only in IDLE; a capture is answered by a
    // one-cycle req_ack, and a valid still held afterwards is a fresh request.
    // rsp_valid pulses once per captured request, with rsp_rdata/rsp_err.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    apb_state_e    state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic [1:0]    grant;
    logic          grant_take;
    logic          xfer_done;
    logic          xfer_tmo;
    logic          owner;

    rr_arb2 u_arb (
        .clk    (PCLK),
        .rst    (PRESET),
        .req    (req_valid),
        .update (grant_take),
        .grant  (grant)
    );

    assign dbg_state = state;

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        grant_take = 1'b0;
        xfer_done  = 1'b0;
        xfer_tmo   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    grant_take = 1'b1;
                    state_nxt  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wait_nxt  = '0;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    xfer_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == TMO_LAST) begin
                    xfer_tmo  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt    <= '0;
            owner       <= 1'b0;
            req_ack     <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
        end else begin
            wait_cnt    <= wait_nxt;
            req_ack     <= '0;
            rsp_valid   <= '0;
            apb.PSEL    <= (state_nxt != ST_IDLE);
            apb.PENABLE <= (state_nxt == ST_ACCESS);
            if (grant_take) begin
                owner      <= grant[1];
                req_ack    <= grant;
                apb.PWRITE <= req_write[grant[1]];
                apb.PADDR  <= grant[1] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                       : req_addr[ADDR_WIDTH-1:0];
                apb.PWDATA <= grant[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : req_wdata[DATA_WIDTH-1:0];
            end
            if (xfer_done) begin
                rsp_valid <= onehot2(owner);
                rsp_rdata <= apb.PWRITE ? '0 : apb.PRDATA;
                rsp_err   <= 1'b0;
            end
            if (xfer_tmo) begin
                rsp_valid <= onehot2(owner);
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: vector table, scoreboard queue and corner-case sequences.
module tb_apb_arb_master;
    import apb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int RW = 2 + 1 + DW;

    typedef struct {
        logic [1:0]    valid;
        logic [1:0]    write;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        int            ws;
        logic [1:0]    exp_ack;
        logic [RW-1:0] exp_rsp;
    } vec_t;

    logic              PCLK;
    logic              PRESET;
    logic [1:0]        req_valid;
    logic [1:0]        req_write;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [1:0]        req_ack;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    apb_state_e        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];

    apb_arb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_arb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state),
        .apb       (bus)
    );

    // Clock / reset
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Completer model: read data derived from address, configurable wait states.
    function automatic logic [DW-1:0] prd(input logic [AW-1:0] a);
        return 32'h5A5A_0000 ^ {22'd0, a};
    endfunction

    function automatic logic [RW-1:0] rsp(input logic [1:0] v, input logic e, input logic [DW-1:0] d);
        return {v, e, d};
    endfunction

    int wait_states = 0;
    int acc_cnt = 0;

    assign bus.PREADY = bus.PSEL && bus.PENABLE && (acc_cnt >= wait_states);
    assign bus.PRDATA = prd(bus.PADDR);

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // Scoreboard
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %b expected no response", rsp_valid);
            end else begin
                check("rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {w1, w0};
    endtask

    task automatic wait_ack(output logic [1:0] ack);
        ack = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            if (req_ack != 2'b00) begin
                ack = req_ack;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge PCLK);
        check("drain_q", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge PCLK);
    endtask

    vec_t vecs[8];

    initial begin
        logic [1:0] ack;
        int n;

        vecs[0] = '{2'b10, 2'b10, 10'h000, 10'h3FF, 32'h0, 32'hDEADBEEF, 0,    2'b10, rsp(2'b10, 1'b0, 32'h0)};
        vecs[1] = '{2'b11, 2'b00, 10'h155, 10'h2AA, 32'h0, 32'h0,        2,    2'b01, rsp(2'b01, 1'b0, prd(10'h155))};
        vecs[2] = '{2'b11, 2'b11, 10'h100, 10'h200, 32'h11111111, 32'h22222222, 1, 2'b10, rsp(2'b10, 1'b0, 32'h0)};
        vecs[3] = '{2'b01, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0,        0,    2'b01, rsp(2'b01, 1'b0, prd(10'h000))};
        vecs[4] = '{2'b01, 2'b00, 10'h3FF, 10'h000, 32'h0, 32'h0,        15,   2'b01, rsp(2'b01, 1'b0, prd(10'h3FF))};
        vecs[5] = '{2'b11, 2'b00, 10'h011, 10'h022, 32'h0, 32'h0,        1000, 2'b10, rsp(2'b10, 1'b1, 32'h0)};
        vecs[6] = '{2'b11, 2'b00, 10'h033, 10'h044, 32'h0, 32'h0,        16,   2'b01, rsp(2'b01, 1'b1, 32'h0)};
        vecs[7] = '{2'b10, 2'b10, 10'h000, 10'h0AA, 32'h0, 32'h12345678, 0,    2'b10, rsp(2'b10, 1'b0, 32'h0)};

        PRESET = 1'b1;
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;

        // Reset state
        check("rst_psel", 64'(bus.PSEL), 64'd0);
        check("rst_penable", 64'(bus.PENABLE), 64'd0);
        check("rst_pwrite", 64'(bus.PWRITE), 64'd0);
        check("rst_paddr", 64'(bus.PADDR), 64'd0);
        check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        check("rst_outputs", 64'({req_ack, rsp_valid, rsp_err, rsp_rdata}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Basic read latency: ack/PSEL at t+1, PENABLE at t+2, response at t+3
        wait_states = 0;
        exp_q.push_back(rsp(2'b01, 1'b0, prd(10'h001)));
        drive(2'b01, 2'b00, 10'h001, 10'h000, '0, '0);
        @(negedge PCLK);
        req_valid = 2'b00;
        check("t1_ack", 64'(req_ack), 64'd1);
        check("t1_psel", 64'(bus.PSEL), 64'd1);
        check("t1_penable", 64'(bus.PENABLE), 64'd0);
        @(negedge PCLK);
        check("t2_psel", 64'(bus.PSEL), 64'd1);
        check("t2_penable", 64'(bus.PENABLE), 64'd1);
        check("t2_ack", 64'(req_ack), 64'd0);
        @(negedge PCLK);
        check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t3_psel", 64'(bus.PSEL), 64'd0);
        drain();

        // Vector table
        for (int i = 0; i < 8; i++) begin
            wait_states = vecs[i].ws;
            exp_q.push_back(vecs[i].exp_rsp);
            drive(vecs[i].valid, vecs[i].write, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1);
            wait_ack(ack);
            req_valid = 2'b00;
            check($sformatf("vec%0d_ack", i), 64'(ack), 64'(vecs[i].exp_ack));
            drain();
        end

        // Both held: grants alternate 0,1,0,1
        wait_states = 0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 0) ? rsp(2'b01, 1'b0, prd(10'h010)) : rsp(2'b10, 1'b0, prd(10'h020)));
        end
        drive(2'b11, 2'b00, 10'h010, 10'h020, '0, '0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(ack);
            if (k == 3) req_valid = 2'b00;
            check($sformatf("alt%0d_ack", k), 64'(ack), (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        drain();

        // Write with 3 wait states: address/data stable through ACCESS
        wait_states = 3;
        exp_q.push_back(rsp(2'b10, 1'b0, 32'h0));
        drive(2'b10, 2'b10, 10'h3C3, 10'h000, 32'hFFFFFFFF, 32'h000000A5);
        wait_ack(ack);
        req_valid = 2'b00;
        check("wr_ack", 64'(ack), 64'd2);
        check("wr_setup_paddr", 64'(bus.PADDR), 64'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            if (!(bus.PSEL && bus.PENABLE)) break;
            n++;
            check($sformatf("wr_paddr_c%0d", n), 64'(bus.PADDR), 64'd0);
            check($sformatf("wr_pwdata_c%0d", n), 64'(bus.PWDATA), 64'hA5);
            check($sformatf("wr_pwrite_c%0d", n), 64'(bus.PWRITE), 64'd1);
        end
        check("wr_access_cycles", 64'(n), 64'd4);
        drain();

        // Timeout: 16 ACCESS cycles then error response and PSEL drop
        wait_states = 1000;
        exp_q.push_back(rsp(2'b01, 1'b1, 32'h0));
        drive(2'b01, 2'b00, 10'h155, 10'h000, '0, '0);
        wait_ack(ack);
        req_valid = 2'b00;
        check("tmo_ack", 64'(ack), 64'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (!bus.PSEL) break;
            if (bus.PENABLE) n++;
        end
        check("tmo_access_cycles", 64'(n), 64'd16);
        check("tmo_psel", 64'(bus.PSEL), 64'd0);
        check("tmo_penable", 64'(bus.PENABLE), 64'd0);
        check("tmo_state", 64'(dbg_state), 64'(ST_IDLE));
        check("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
        drain();

        // Reset mid-ACCESS: abort silently, pointer back to requester 0
        wait_states = 1000;
        drive(2'b01, 2'b00, 10'h0AA, 10'h000, '0, '0);
        wait_ack(ack);
        req_valid = 2'b00;
        check("abort_ack", 64'(ack), 64'd1);
        repeat (3) @(negedge PCLK);
        check("abort_in_access", 64'(bus.PENABLE), 64'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        check("abort_psel", 64'(bus.PSEL), 64'd0);
        check("abort_penable", 64'(bus.PENABLE), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (4) @(negedge PCLK);
        wait_states = 0;
        exp_q.push_back(rsp(2'b01, 1'b0, prd(10'h011)));
        drive(2'b11, 2'b00, 10'h011, 10'h022, '0, '0);
        wait_ack(ack);
        req_valid = 2'b00;
        check("post_rst_contention", 64'(ack), 64'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
